// File: rtl/picosoc_bus_pkg.sv
// picosoc_bus_pkg: shared state encoding and default address map for the picosoc I/O bus
package picosoc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [127:0] DEF_SLV_BASE  = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
    localparam logic [127:0] DEF_SLV_MASK  = {4{32'hFF00_0000}};
    localparam logic [31:0]  DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_iobus_decode.sv
// picosoc_iobus_decode: base/mask address decode with lowest-index priority
module picosoc_iobus_decode
    import picosoc_bus_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [31:0]     m_addr,
    output logic [NSLV-1:0] hit,
    output logic            hit_any
);

    // scan from the top index down so the lowest matching window overrides
    always_comb begin
        hit = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if ((m_addr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32]))
                hit = NSLV'(1) << i;
    end

    assign hit_any = |hit;

endmodule

// File: rtl/picosoc_iobus.sv
// picosoc_iobus: single-master multi-slave bus fabric with timeout and error reporting
module picosoc_iobus
    import picosoc_bus_pkg::*;
#(
    parameter int                 NSLV      = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE  = DEF_SLV_BASE,
    parameter logic [NSLV*32-1:0] SLV_MASK  = DEF_SLV_MASK,
    parameter int                 TIMEOUT   = 255,
    parameter logic [31:0]        ERR_RDATA = DEF_ERR_RDATA,
    parameter int                 CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_valid,
    input  logic                 m_instr,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    output logic                 m_ready,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_valid,
    output logic                 s_instr,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [NSLV-1:0]      s_ready,
    input  logic [NSLV*32-1:0]   s_rdata,
    input  logic                 err_clr,
    output logic                 err_irq,
    output logic [CNT_W-1:0]     err_count,
    output logic [31:0]          err_addr
);

    state_t           state;
    logic [15:0]      cnt, cnt_nxt;
    logic [NSLV-1:0]  hit;
    logic             hit_any, rdy, timeout, req, err;
    logic [31:0]      rdata_sel, err_a;
    logic [CNT_W-1:0] cnt_base, cnt_sat;

    picosoc_iobus_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .m_addr  (m_addr),
        .hit     (hit),
        .hit_any (hit_any)
    );

    // response select, timeout detect and error bookkeeping; err_clr is applied before the increment so a coincident error yields 1
    always_comb begin
        rdy       = |(s_ready & s_valid);
        rdata_sel = '0;
        for (int i = 0; i < NSLV; i++)
            rdata_sel = rdata_sel | (s_valid[i] ? s_rdata[i*32 +: 32] : 32'h0);
        cnt_nxt   = cnt + 16'd1;
        timeout   = cnt_nxt == 16'(TIMEOUT);
        req       = state == ST_IDLE && m_valid && !m_ready;
        err       = (req && !hit_any) || (state == ST_WAIT && !rdy && timeout);
        err_a     = state == ST_IDLE ? m_addr : s_addr;
        cnt_base  = err_clr ? '0 : err_count;
        cnt_sat   = &cnt_base ? cnt_base : cnt_base + CNT_W'(1);
    end

    // bus FSM; m_ready follows RESP by one cycle so the held m_valid is never re-accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            m_ready   <= 1'b0;
            m_rdata   <= '0;
            s_valid   <= '0;
            s_instr   <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            err_irq   <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            m_ready <= state == ST_RESP;
            err_irq <= err;
            if (err) begin
                err_count <= cnt_sat;
                err_addr  <= err_a;
            end else if (err_clr) begin
                err_count <= '0;
                err_addr  <= '0;
            end
            case (state)
                ST_IDLE: if (req) begin
                    if (hit_any) begin
                        s_valid <= hit;
                        s_instr <= m_instr;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        cnt     <= '0;
                        state   <= ST_WAIT;
                    end else begin
                        m_rdata <= ERR_RDATA;
                        state   <= ST_RESP;
                    end
                end
                ST_WAIT: if (rdy || timeout) begin
                    m_rdata <= rdy ? rdata_sel : 32'h0;
                    s_valid <= '0;
                    state   <= ST_RESP;
                end else begin
                    cnt <= cnt_nxt;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_iobus.sv
// tb_picosoc_iobus: randomized self-checking bench against a transaction-level model
module tb_picosoc_iobus;

    logic         clk = 1'b0;
    logic         reset, m_valid, m_instr, err_clr;
    logic [31:0]  m_addr, m_wdata;
    logic [3:0]   m_wstrb, s_ready;
    logic [127:0] s_rdata;
    logic         m_ready, s_instr, err_irq;
    logic [31:0]  m_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]   s_valid, s_wstrb;
    logic [7:0]   err_count;

    int total = 0, bad = 0;
    int first_sv, sv_cyc, mr_j, mr_cnt, irq_j, irq_cnt;
    logic [3:0]  sv_or, o_wstrb;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_instr;
    int          mdl_cnt;
    logic [31:0] mdl_addr;

    always #5 clk = ~clk;

    picosoc_iobus dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_clr(err_clr),
        .err_irq(err_irq), .err_count(err_count), .err_addr(err_addr)
    );

    // default map: slave i owns the 16 MB window whose top byte equals i
    function automatic int exp_slave(input logic [31:0] a);
        return (a[31:24] < 8'd4) ? int'(a[31:24]) : -1;
    endfunction

    function automatic void mdl_error(input logic [31:0] a, input bit clr);
        if (clr) mdl_cnt = 0;
        mdl_cnt  = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
        mdl_addr = a;
    endfunction

    // one CPU transaction with a behavioural slave answering after dly WAIT cycles (dly<0: never)
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input logic ins, input int dly, input logic [31:0] rd,
                           input logic [3:0] noise_in, input logic clr0);
        int k, w, stop;
        logic [3:0] noise;
        k = exp_slave(a);
        noise = (k >= 0) ? noise_in & ~4'(1 << k) : noise_in;
        first_sv = -1; sv_cyc = 0; mr_j = -1; mr_cnt = 0; irq_j = -1; irq_cnt = 0;
        sv_or = '0; w = 0; stop = 600;
        @(negedge clk);
        m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; m_instr = ins;
        err_clr = clr0; s_ready = noise;
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (k >= 0) s_rdata[k*32 +: 32] = rd;
        for (int j = 1; j <= stop; j++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (s_valid != 4'b0) begin
                sv_cyc++; sv_or |= s_valid; w++;
                if (first_sv < 0) first_sv = j;
                o_addr = s_addr; o_wdata = s_wdata; o_wstrb = s_wstrb; o_instr = s_instr;
            end
            if (m_ready) begin
                mr_cnt++;
                if (mr_j < 0) begin mr_j = j; o_rdata = m_rdata; stop = j + 3; end
            end
            if (err_irq) begin irq_cnt++; if (irq_j < 0) irq_j = j; end
            if (mr_j >= 0 && j == mr_j + 1) m_valid = 1'b0;
            s_ready = noise | ((s_valid != 4'b0 && k >= 0 && dly >= 0 && w == dly + 1) ? 4'(1 << k) : 4'b0);
        end
        m_valid = 1'b0; s_ready = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 0; m_instr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        s_ready = 0; s_rdata = 0; err_clr = 0;
        mdl_cnt = 0; mdl_addr = 0;
        repeat (3) @(negedge clk);
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL rst_m_ready got=%b exp=0", m_ready); end
        total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL rst_m_rdata got=%h exp=0", m_rdata); end
        total++; if (s_valid !== 4'h0) begin bad++; $display("FAIL rst_s_valid got=%b exp=0", s_valid); end
        total++; if ({s_instr, s_addr, s_wdata, s_wstrb} !== 69'h0) begin bad++; $display("FAIL rst_s_bus got=%b %h %h %b exp=0", s_instr, s_addr, s_wdata, s_wstrb); end
        total++; if ({err_irq, err_count, err_addr} !== 41'h0) begin bad++; $display("FAIL rst_err got=%b %0d %h exp=0", err_irq, err_count, err_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        run_txn(32'h0100_0010, 32'h0, 4'b0000, 1'b1, 0, 32'h1234_5678, 4'b0000, 1'b0);
        total++; if (first_sv !== 1) begin bad++; $display("FAIL read_sv_start got=%0d exp=1", first_sv); end
        total++; if (sv_or !== 4'b0010) begin bad++; $display("FAIL read_sv got=%b exp=0010", sv_or); end
        total++; if (mr_j !== 3) begin bad++; $display("FAIL read_lat got=%0d exp=3", mr_j); end
        total++; if (mr_cnt !== 1) begin bad++; $display("FAIL read_pulses got=%0d exp=1", mr_cnt); end
        total++; if (o_rdata !== 32'h1234_5678) begin bad++; $display("FAIL read_rdata got=%h exp=12345678", o_rdata); end
        total++; if (o_instr !== 1'b1 || o_addr !== 32'h0100_0010) begin bad++; $display("FAIL read_req got=%b %h exp=1 01000010", o_instr, o_addr); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL read_errcnt got=%0d exp=0", err_count); end
    endtask

    task automatic test_write();
        run_txn(32'h0300_0004, 32'h00AB_0000, 4'b0100, 1'b0, 5, 32'hCAFE_0001, 4'b0000, 1'b0);
        total++; if (o_wstrb !== 4'b0100 || o_wdata !== 32'h00AB_0000) begin bad++; $display("FAIL write_bus got=%b %h exp=0100 00ab0000", o_wstrb, o_wdata); end
        total++; if (sv_or !== 4'b1000 || sv_cyc !== 6) begin bad++; $display("FAIL write_sv got=%b/%0d exp=1000/6", sv_or, sv_cyc); end
        total++; if (mr_cnt !== 1 || mr_j !== 8) begin bad++; $display("FAIL write_resp got=%0d@%0d exp=1@8", mr_cnt, mr_j); end
    endtask

    task automatic test_miss();
        run_txn(32'h0400_0000, 32'h5555_5555, 4'b1111, 1'b0, 0, 32'h0, 4'b0000, 1'b0);
        mdl_error(32'h0400_0000, 1'b0);
        total++; if (mr_j !== 2 || mr_cnt !== 1) begin bad++; $display("FAIL miss_lat got=%0d@%0d exp=1@2", mr_cnt, mr_j); end
        total++; if (o_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL miss_rdata got=%h exp=deadbeef", o_rdata); end
        total++; if (irq_cnt !== 1 || irq_j !== 1) begin bad++; $display("FAIL miss_irq got=%0d@%0d exp=1@1", irq_cnt, irq_j); end
        total++; if (sv_cyc !== 0) begin bad++; $display("FAIL miss_sv got=%0d exp=0", sv_cyc); end
        total++; if (err_count !== 8'(mdl_cnt) || err_addr !== mdl_addr) begin bad++; $display("FAIL miss_err got=%0d %h exp=%0d %h", err_count, err_addr, mdl_cnt, mdl_addr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, wd, rd;
            logic [3:0] ws;
            logic ins;
            int dly, k;
            a = {8'($urandom_range(0, 5)), 24'($urandom)};
            wd = $urandom; rd = $urandom; ws = 4'($urandom); ins = 1'($urandom); dly = $urandom_range(0, 6);
            k = exp_slave(a);
            run_txn(a, wd, ws, ins, dly, rd, 4'($urandom), 1'b0);
            if (k < 0) begin
                mdl_error(a, 1'b0);
                total++; if (o_rdata !== 32'hDEAD_BEEF || mr_j !== 2 || sv_cyc !== 0) begin bad++; $display("FAIL rnd_miss[%0d] got=%h@%0d sv=%0d exp=deadbeef@2 sv=0", n, o_rdata, mr_j, sv_cyc); end
            end else begin
                total++; if (o_rdata !== rd || mr_j !== dly + 3) begin bad++; $display("FAIL rnd_hit[%0d] got=%h@%0d exp=%h@%0d", n, o_rdata, mr_j, rd, dly + 3); end
                total++; if (sv_or !== 4'(1 << k) || o_addr !== a || o_wdata !== wd || o_wstrb !== ws || o_instr !== ins) begin bad++; $display("FAIL rnd_req[%0d] got=%b %h %h %b %b exp=%b %h %h %b %b", n, sv_or, o_addr, o_wdata, o_wstrb, o_instr, 4'(1 << k), a, wd, ws, ins); end
            end
            total++; if (mr_cnt !== 1) begin bad++; $display("FAIL rnd_pulses[%0d] got=%0d exp=1", n, mr_cnt); end
        end
        total++; if (err_count !== 8'(mdl_cnt) || err_addr !== mdl_addr) begin bad++; $display("FAIL rnd_err got=%0d %h exp=%0d %h", err_count, err_addr, mdl_cnt, mdl_addr); end
    endtask

    task automatic test_timeout();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        mdl_cnt = 0; mdl_addr = 0;
        run_txn(32'h0200_0000, 32'h0, 4'b0000, 1'b0, -1, 32'h7777_7777, 4'b1011, 1'b0);
        mdl_error(32'h0200_0000, 1'b0);
        total++; if (sv_cyc !== 255 || mr_j !== 257) begin bad++; $display("FAIL to_len got=%0d@%0d exp=255@257", sv_cyc, mr_j); end
        total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", o_rdata); end
        total++; if (irq_j !== 256 || irq_cnt !== 1) begin bad++; $display("FAIL to_irq got=%0d@%0d exp=1@256", irq_cnt, irq_j); end
        total++; if (err_count !== 8'(mdl_cnt) || err_addr !== mdl_addr) begin bad++; $display("FAIL to_err1 got=%0d %h exp=%0d %h", err_count, err_addr, mdl_cnt, mdl_addr); end
        run_txn(32'h0200_0100, 32'h0, 4'b0000, 1'b0, -1, 32'h0, 4'b0000, 1'b0);
        mdl_error(32'h0200_0100, 1'b0);
        total++; if (err_count !== 8'd2 || err_count !== 8'(mdl_cnt) || err_addr !== mdl_addr) begin bad++; $display("FAIL to_err2 got=%0d %h exp=%0d %h", err_count, err_addr, mdl_cnt, mdl_addr); end
        run_txn(32'h0200_0200, 32'h0, 4'b0000, 1'b0, 254, 32'h0BAD_F00D, 4'b0000, 1'b0);
        total++; if (o_rdata !== 32'h0BAD_F00D || mr_j !== 257 || irq_cnt !== 0) begin bad++; $display("FAIL to_last_ready got=%h@%0d irq=%0d exp=0badf00d@257 irq=0", o_rdata, mr_j, irq_cnt); end
        total++; if (err_count !== 8'(mdl_cnt)) begin bad++; $display("FAIL to_noerr got=%0d exp=%0d", err_count, mdl_cnt); end
    endtask

    task automatic test_saturate();
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            a = {8'($urandom_range(4, 255)), 24'($urandom)};
            run_txn(a, 32'h0, 4'b0000, 1'b0, 0, 32'h0, 4'b0000, 1'b0);
            mdl_error(a, 1'b0);
        end
        total++; if (err_count !== 8'd255 || err_count !== 8'(mdl_cnt) || err_addr !== mdl_addr) begin bad++; $display("FAIL sat got=%0d %h exp=255 %h", err_count, err_addr, mdl_addr); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total++; if (err_count !== 8'd0 || err_addr !== 32'h0) begin bad++; $display("FAIL clr got=%0d %h exp=0 0", err_count, err_addr); end
        run_txn(32'h0900_1234, 32'h0, 4'b0000, 1'b0, 0, 32'h0, 4'b0000, 1'b1);
        mdl_error(32'h0900_1234, 1'b1);
        total++; if (err_count !== 8'd1 || err_addr !== 32'h0900_1234) begin bad++; $display("FAIL clr_and_err got=%0d %h exp=1 09001234", err_count, err_addr); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0000_0040; m_wstrb = 4'b0000; s_ready = 4'b0;
        for (int j = 0; j < 10 && s_valid == 4'b0; j++) @(negedge clk);
        total++; if (s_valid !== 4'b0001) begin bad++; $display("FAIL mid_pending got=%b exp=0001", s_valid); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (s_valid !== 4'b0 || m_ready !== 1'b0 || err_count !== 8'd0) begin bad++; $display("FAIL mid_reset got=%b %b %0d exp=0 0 0", s_valid, m_ready, err_count); end
        m_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        mdl_cnt = 0; mdl_addr = 0;
        run_txn(32'h0000_0080, 32'h0, 4'b0000, 1'b0, 2, 32'hA5A5_0F0F, 4'b0110, 1'b0);
        total++; if (o_rdata !== 32'hA5A5_0F0F || mr_j !== 5 || mr_cnt !== 1) begin bad++; $display("FAIL mid_after got=%h@%0d x%0d exp=a5a50f0f@5 x1", o_rdata, mr_j, mr_cnt); end
        total++; if (err_count !== 8'(mdl_cnt)) begin bad++; $display("FAIL mid_err got=%0d exp=%0d", err_count, mdl_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_random();
        test_timeout();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
